// File: rtl/keccak_pkg.sv
// Shared Keccak constants, mode encodings and helpers.
// Provides the lane width, the SHAKE rates and words per block, the
// operation mode vectors, the dump FSM state type and EndianSwitcher,
// which reverses the byte order of one lane.
package keccak_pkg;

    localparam int w           = 64;
    localparam int w_byte_size = w / 8;

    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    localparam int WORDS_SHAKE128 = RATE_SHAKE128 / w;  // 21
    localparam int WORDS_SHAKE256 = RATE_SHAKE256 / w;  // 17

    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;

    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_WAIT_BLOCK,
        DUMP_SEND
    } dump_state_t;

    // Lanes are little-endian; the output stream wants byte 0 in the MSBs.
    function automatic logic [w-1:0] EndianSwitcher(input logic [w-1:0] lane);
        logic [w-1:0] swapped;
        swapped = '0;
        for (int unsigned i = 0; i < w_byte_size; i++) begin
            swapped[(w_byte_size - 1 - i) * 8 +: 8] = lane[i * 8 +: 8];
        end
        return swapped;
    endfunction

endpackage

// File: rtl/dump_datapath_if.sv
// Output word stream of the dump datapath.
//   data_out       : output word, stream byte order
//   data_out_valid : data_out holds a word
//   data_out_ready : sink accepts the word this cycle
//   last_word      : the valid word is the final word of the job
// master = producer (dump_datapath), slave = consumer.
interface dump_datapath_if;
    import keccak_pkg::*;

    logic [w-1:0] data_out;
    logic         data_out_valid;
    logic         data_out_ready;
    logic         last_word;

    modport master (
        output data_out,
        output data_out_valid,
        output last_word,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  last_word,
        output data_out_ready
    );

endinterface

// File: rtl/dump_datapath_piso_buffer.sv
// piso_buffer: parallel-in, serial-out buffer of DEPTH words of WIDTH bits.
//   clk, rst : clock, asynchronous active-low reset (clears the buffer)
//   load     : capture data_in (takes priority over en)
//   en       : shift right by one word
//   data_in  : WIDTH*DEPTH bits, word 0 in the LSBs
//   data_out : current word 0
module piso_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     en,
    input  logic [WIDTH*DEPTH-1:0]   data_in,
    output logic [WIDTH-1:0]         data_out
);

    logic [WIDTH*DEPTH-1:0] buf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q <= data_in;
        end else if (en) begin
            buf_q <= buf_q >> WIDTH;
        end
    end

    assign data_out = buf_q[WIDTH-1:0];

endmodule

// File: rtl/dump_datapath.sv
// dump_datapath: serialises squeeze blocks into byte-swapped W-bit words.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : latch operation_mode/output_size, begin a job (IDLE only)
//   operation_mode  : SHAKE128_MODE_VEC / SHAKE256_MODE_VEC
//   output_size     : requested length in bits (byte granular)
//   rate_output     : squeeze block, lane 0 in the LSBs
//   block_valid     : rate_output valid
//   block_ready     : block accepted on block_valid && block_ready
//   more_blocks     : another squeeze permutation is needed
//   out_if          : output word stream (data/valid/ready/last_word)
//   busy            : job in progress
//   done            : one-cycle pulse at job completion
module dump_datapath
    import keccak_pkg::*;
#(
    parameter int W    = w,
    parameter int RATE = RATE_SHAKE128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        operation_mode,
    input  logic [31:0]       output_size,
    input  logic [RATE-1:0]   rate_output,
    input  logic              block_valid,
    output logic              block_ready,
    output logic              more_blocks,
    dump_datapath_if.master   out_if,
    output logic              busy,
    output logic              done
);

    localparam logic [W-1:0] ALL_ONES = '1;

    dump_state_t  state;
    logic [1:0]   mode_q;
    logic [28:0]  bytes_left;
    logic [4:0]   word_cnt;
    logic [4:0]   words_per_block;
    logic         valid_q;
    logic         load;
    logic         shift;
    logic [W-1:0] piso_word;
    logic [W-1:0] swapped;
    logic [W-1:0] byte_mask;
    logic         unused_size_bits;

    assign unused_size_bits = ^output_size[2:0];

    assign words_per_block = (mode_q == SHAKE256_MODE_VEC) ? 5'(WORDS_SHAKE256)
                                                           : 5'(WORDS_SHAKE128);

    assign load  = (state == DUMP_WAIT_BLOCK) && block_valid;
    assign shift = (state == DUMP_SEND) && out_if.data_out_ready;

    piso_buffer #(
        .WIDTH (W),
        .DEPTH (RATE / W)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en       (shift),
        .data_in  (rate_output),
        .data_out (piso_word)
    );

    assign swapped = EndianSwitcher(piso_word);

    // Partial final word: keep the leading n bytes (MSBs), zero the rest.
    always_comb begin
        byte_mask = ALL_ONES;
        if (bytes_left < 29'd8) begin
            byte_mask = ~(ALL_ONES >> {bytes_left[2:0], 3'b000});
        end
    end

    assign out_if.data_out       = swapped & byte_mask;
    assign out_if.data_out_valid = valid_q;
    assign out_if.last_word      = valid_q && (bytes_left <= 29'd8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= DUMP_IDLE;
            mode_q      <= '0;
            bytes_left  <= '0;
            word_cnt    <= '0;
            valid_q     <= 1'b0;
            block_ready <= 1'b0;
            more_blocks <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DUMP_IDLE: begin
                    if (start) begin
                        mode_q     <= operation_mode;
                        bytes_left <= output_size[31:3];
                        if (output_size[31:3] == 29'd0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= DUMP_WAIT_BLOCK;
                            block_ready <= 1'b1;
                            more_blocks <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end

                DUMP_WAIT_BLOCK: begin
                    if (block_valid) begin
                        word_cnt    <= words_per_block;
                        state       <= DUMP_SEND;
                        block_ready <= 1'b0;
                        more_blocks <= 1'b0;
                        valid_q     <= 1'b1;
                    end
                end

                DUMP_SEND: begin
                    if (out_if.data_out_ready) begin
                        word_cnt <= word_cnt - 5'd1;
                        if (bytes_left <= 29'd8) begin
                            bytes_left <= '0;
                            state      <= DUMP_IDLE;
                            valid_q    <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            bytes_left <= bytes_left - 29'd8;
                            if (word_cnt == 5'd1) begin
                                state       <= DUMP_WAIT_BLOCK;
                                valid_q     <= 1'b0;
                                block_ready <= 1'b1;
                                more_blocks <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state       <= DUMP_IDLE;
                    valid_q     <= 1'b0;
                    block_ready <= 1'b0;
                    more_blocks <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dump_datapath.md
Name: dump_datapath

Overview:
- Output-side counterpart of the absorb/load path.
- Accepts one full rate-wide squeeze block from the permutation stage and serializes it into w-bit words with a valid/ready handshake.
- Converts each lane from little-endian to stream byte order and zeroes unused bytes of the final partial word.
- Requests further squeeze blocks until the job's output size has been delivered.

Parameters:
W, 64 (package w), output word width in bits
RATE, 1344 (package RATE_SHAKE128), maximum block width in bits; must be a multiple of W

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  latch operation_mode/output_size and begin a job; honoured only in IDLE
operation_mode  in  2  SHAKE128_MODE_VEC or SHAKE256_MODE_VEC
output_size  in  32  requested output length in bits; bits [2:0] ignored (byte granular)
rate_output  in  RATE  squeeze block; lane 0 = bits [W-1:0]
block_valid  in  1  rate_output valid
block_ready  out  1  block accepted when block_valid && block_ready
more_blocks  out  1  high in WAIT_BLOCK: another squeeze permutation is required
data_out  out  W  output word
data_out_valid  out  1  data_out valid
data_out_ready  in  1  downstream accepts word
last_word  out  1  qualifies the final word of the job (with data_out_valid)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - PISO, byte counter and word counter cleared.
  - Reset mid-job discards all remaining output; no done pulse.
- Latched on start in IDLE:
  - mode register.
  - bytes_left = output_size[31:3] (29 bits).
  - words_per_block = 17 for SHAKE256_MODE_VEC, 21 for SHAKE128_MODE_VEC or any other code.
- IDLE:
  - start with bytes_left input == 0 → done pulses next cycle, state stays IDLE.
  - start with nonzero size → WAIT_BLOCK.
- WAIT_BLOCK:
  - block_ready=1, more_blocks=1.
  - On handshake: PISO parallel-loads rate_output, word_cnt=words_per_block, state→SEND.
  - data_out_valid rises the cycle after the handshake (1-cycle latency).
  - block_ready drops in that same cycle.
- SEND:
  - data_out_valid=1.
  - data_out = EndianSwitcher(PISO[W-1:0]), then masked.
  - data_out and data_out_valid are held stable until data_out_ready.
  - On transfer: PISO shifts right by W, word_cnt-=1, bytes_left -= min(bytes_left, 8).
  - Transfer with bytes_left<=8 (last_word=1) → IDLE, with a done pulse in the following cycle.
  - Otherwise, transfer with word_cnt==1 → WAIT_BLOCK.
  - Otherwise → stay in SEND.
- Masking: when bytes_left = n < 8, keep data_out[W-1 -: 8n] and force the low W-8n bits to 0. n≥8 → no mask.
- last_word = (state==SEND) && (bytes_left<=8).
- start outside IDLE is ignored.
- block_valid outside WAIT_BLOCK is ignored (no load).
- In SHAKE256 mode, PISO bits above 17*W are loaded but never emitted.
- No combinational path from data_out_ready or block_valid to any output.

Decomposition:
- keccak_pkg already provides w, w_byte_size, RATE_SHAKE128, the mode vectors and EndianSwitcher.
- Add to keccak_pkg:
  - RATE_SHAKE256 (1088).
  - WORDS_SHAKE128=21 and WORDS_SHAKE256=17.
  - typedef enum dump_state_t {DUMP_IDLE, DUMP_WAIT_BLOCK, DUMP_SEND}.
- One sub-module: piso_buffer (WIDTH, DEPTH; inputs load, en, data_in[WIDTH*DEPTH]; output data_out[WIDTH]).
  - Parallel load has priority over shift.
  - Mirrors the existing sipo_buffer.

Test Plan:
1. SHAKE128, output_size=256, lane k = 64'h0011223344556677+k → 4 words, each the byte-swap of its lane (word0 = 64'h7766554433221100); last_word on word 3; done pulse; block_ready stays 0 afterwards.
2. SHAKE256, output_size=1152 → 17 words, then WAIT_BLOCK with more_blocks=1; second block → 1 word with last_word=1; 18 words total.
3. SHAKE128, output_size=104 (13 bytes) → word1 keeps the top 5 bytes, low 24 bits = 0, last_word=1.
4. Random data_out_ready backpressure over 3 blocks of SHAKE128, output_size=4032 → data_out stable while stalled; 63 words, in order, no loss or duplication.
5. rst pulled low during SEND word 5 → all outputs 0 immediately; after release, a new start with output_size=64 completes normally with 1 word.
6. start with output_size=7 (0 bytes) → done pulses next cycle; block_ready never asserted; busy stays 0.
